// File: rtl/alu_pkg.sv
// Shared command/datapath codes, flag indices and sequencer state type for the ALU
// command sequencer.
package alu_pkg;

    localparam logic [2:0] CMD_ADD     = 3'd0;
    localparam logic [2:0] CMD_SUB     = 3'd1;
    localparam logic [2:0] CMD_AND     = 3'd2;
    localparam logic [2:0] CMD_OR      = 3'd3;
    localparam logic [2:0] CMD_XOR     = 3'd4;
    localparam logic [2:0] CMD_ABSDIFF = 3'd5;
    localparam logic [2:0] CMD_MUL     = 3'd6;
    localparam logic [2:0] CMD_CMP     = 3'd7;

    localparam logic [2:0] DP_OP_ADD = 3'd0;
    localparam logic [2:0] DP_OP_SUB = 3'd1;
    localparam logic [2:0] DP_OP_AND = 3'd2;
    localparam logic [2:0] DP_OP_OR  = 3'd3;
    localparam logic [2:0] DP_OP_XOR = 3'd4;

    localparam int FLAG_NE = 0;
    localparam int FLAG_EQ = 1;
    localparam int FLAG_LT = 2;
    localparam int FLAG_GT = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_ABS  = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } alu_seq_state_t;

endpackage

// File: rtl/alu_mul_step.sv
// Shift-and-add multiplier bookkeeping: holds accumulator, multiplicand, multiplier and
// iteration count; the addition itself is done by the external datapath (dp_r).
module alu_mul_step #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    input  logic [WIDTH-1:0] dp_r,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] mcand_next,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // dp_r is acc_q + mcand_q while stepping, so it is only taken when the
    // current multiplier bit is set.
    assign acc_next   = mplier_q[0] ? dp_r : acc_q;
    assign mcand_next = mcand_q << 1;
    assign done       = step && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: every _d gets a default before any branch so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_next;
            mcand_d  = mcand_next;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle command sequencer: drives the registered datapath interface (dp_*) and
// builds ABSDIFF, MUL and CMP out of plain datapath passes.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_cmd,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_r,
    output logic [3:0]       resp_flags,
    output logic [2:0]       dp_op,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic [WIDTH-1:0] dp_r,
    input  logic [3:0]       dp_flags
);

    alu_seq_state_t   state_q, state_d;
    logic [2:0]       cmd_q,   cmd_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] r_q,     r_d;
    logic [3:0]       flags_q, flags_d;
    logic [2:0]       dp_op_q, dp_op_d;
    logic [WIDTH-1:0] dp_a_q,  dp_a_d;
    logic [WIDTH-1:0] dp_b_q,  dp_b_d;
    logic             rdy_q,   rdy_d;

    logic             mul_load;
    logic             mul_step;
    logic             mul_done;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand_next;

    alu_mul_step #(.WIDTH(WIDTH)) u_mul_step (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mul_load),
        .a          (a_q),
        .b          (b_q),
        .step       (mul_step),
        .dp_r       (dp_r),
        .acc_next   (acc_next),
        .mcand_next (mcand_next),
        .done       (mul_done)
    );

    // Ready is a flop so it stays low throughout reset and rises one edge after release.
    assign req_ready  = rdy_q;
    assign resp_valid = (state_q == ST_DONE);
    assign resp_r     = r_q;
    assign resp_flags = flags_q;
    assign dp_op      = dp_op_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        flags_d  = flags_q;
        dp_op_d  = dp_op_q;
        dp_a_d   = dp_a_q;
        dp_b_d   = dp_b_q;
        mul_load = 1'b0;
        mul_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && rdy_q) begin
                    cmd_d   = req_cmd;
                    a_d     = req_a;
                    b_d     = req_b;
                    dp_a_d  = req_a;
                    dp_b_d  = req_b;
                    dp_op_d = (req_cmd < CMD_ABSDIFF) ? req_cmd : DP_OP_SUB;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                flags_d = dp_flags;
                case (cmd_q)
                    CMD_ABSDIFF: begin
                        if (dp_flags[FLAG_LT]) begin
                            dp_a_d = b_q;
                            dp_b_d = a_q;
                        end
                        dp_op_d = DP_OP_SUB;
                        state_d = ST_ABS;
                    end
                    CMD_MUL: begin
                        mul_load = 1'b1;
                        dp_op_d  = DP_OP_ADD;
                        dp_a_d   = '0;
                        dp_b_d   = a_q;
                        state_d  = ST_MUL;
                    end
                    CMD_CMP: begin
                        r_d     = '0;
                        state_d = ST_DONE;
                    end
                    default: begin
                        r_d     = dp_r;
                        state_d = ST_DONE;
                    end
                endcase
            end
            ST_ABS: begin
                r_d     = dp_r;
                state_d = ST_DONE;
            end
            ST_MUL: begin
                // Present next acc/mcand so dp_r is their sum during the following step.
                mul_step = 1'b1;
                dp_a_d   = acc_next;
                dp_b_d   = mcand_next;
                if (mul_done) begin
                    r_d     = acc_next;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
            dp_op_q <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            dp_op_q <= dp_op_d;
            dp_a_q  <= dp_a_d;
            dp_b_q  <= dp_b_d;
            rdy_q   <= rdy_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a behavioural datapath, a driver that queues expected
// responses, and a monitor that checks every presented response against the queue.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_cmd;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_r;
    logic [3:0]       resp_flags;
    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_r;
    logic [3:0]       dp_flags;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_r     (resp_r),
        .resp_flags (resp_flags),
        .dp_op      (dp_op),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_r       (dp_r),
        .dp_flags   (dp_flags)
    );

    // Stand-in for alu_dp.
    always_comb begin
        case (dp_op)
            DP_OP_ADD: dp_r = dp_a + dp_b;
            DP_OP_SUB: dp_r = dp_a - dp_b;
            DP_OP_AND: dp_r = dp_a & dp_b;
            DP_OP_OR:  dp_r = dp_a | dp_b;
            DP_OP_XOR: dp_r = dp_a ^ dp_b;
            default:   dp_r = '0;
        endcase
        dp_flags = {dp_a > dp_b, dp_a < dp_b, dp_a == dp_b, dp_a != dp_b};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: response valid must first be seen in the cycle before edge T+n.
    bit prev_valid = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else if (resp_valid) begin
            if (sb.size() == 0) begin
                fail_now($sformatf("unexpected_resp r=%0h flags=%b at cycle %0d", resp_r, resp_flags, cyc));
            end else begin
                if (!prev_valid)
                    check({sb[0].name, " latency"}, 64'(cyc), 64'(sb[0].due - 1));
                check({sb[0].name, " r"}, 64'(resp_r), 64'(sb[0].r));
                check({sb[0].name, " flags"}, 64'(resp_flags), 64'(sb[0].f));
                if (resp_ready) void'(sb.pop_front());
            end
            prev_valid = !resp_ready;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic issue(input vec_t v, input bit push);
        int waited = 0;
        @(posedge clk); #1;
        while (!req_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            fail_now({v.name, " req_ready_timeout"});
            return;
        end
        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_a     = v.a;
        req_b     = v.b;
        if (push) sb.push_back('{r: v.r, f: v.f, due: cyc + 1 + v.lat, name: v.name});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t v;
        int   waited;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_cmd    = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst req_ready", 64'(req_ready), 64'(0));
        check("rst resp_valid", 64'(resp_valid), 64'(0));
        check("rst resp_r", 64'(resp_r), 64'(0));
        check("rst resp_flags", 64'(resp_flags), 64'(0));
        check("rst dp_op", 64'(dp_op), 64'(0));
        check("rst dp_a", 64'(dp_a), 64'(0));
        check("rst dp_b", 64'(dp_b), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst req_ready", 64'(req_ready), 64'(1));
        check("post_rst resp_valid", 64'(resp_valid), 64'(0));

        vecs.push_back('{CMD_ADD,     32'd7,          32'd5,          32'd12,         4'b1001, 2,  "add_7_5"});
        vecs.push_back('{CMD_SUB,     32'd5,          32'd7,          32'hFFFF_FFFE,  4'b0101, 2,  "sub_5_7"});
        vecs.push_back('{CMD_ADD,     32'hFFFF_FFFF,  32'd1,          32'd0,          4'b1001, 2,  "add_wrap"});
        vecs.push_back('{CMD_AND,     32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200,  4'b1001, 2,  "and"});
        vecs.push_back('{CMD_OR,      32'hF0F0_1234,  32'h0FF0_FF00,  32'hFFF0_FF34,  4'b1001, 2,  "or"});
        vecs.push_back('{CMD_XOR,     32'hF0F0_1234,  32'h0FF0_FF00,  32'hFF00_ED34,  4'b1001, 2,  "xor"});
        vecs.push_back('{CMD_ABSDIFF, 32'd3,          32'd10,         32'd7,          4'b0101, 3,  "absdiff_3_10"});
        vecs.push_back('{CMD_ABSDIFF, 32'd10,         32'd3,          32'd7,          4'b1001, 3,  "absdiff_10_3"});
        vecs.push_back('{CMD_ABSDIFF, 32'd9,          32'd9,          32'd0,          4'b0010, 3,  "absdiff_9_9"});
        vecs.push_back('{CMD_MUL,     32'd12345,      32'd678,        32'd8369910,    4'b1001, 34, "mul_12345_678"});
        vecs.push_back('{CMD_MUL,     32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  4'b1001, 34, "mul_wrap"});
        vecs.push_back('{CMD_MUL,     32'd0,          32'd7,          32'd0,          4'b0101, 34, "mul_zero"});
        vecs.push_back('{CMD_CMP,     32'd5,          32'd5,          32'd0,          4'b0010, 2,  "cmp_5_5"});

        foreach (vecs[i]) issue(vecs[i], 1'b1);
        wait_drain();

        // Backpressure: response held for 5 cycles while a new request is offered.
        resp_ready = 1'b0;
        issue('{CMD_ADD, 32'd100, 32'd23, 32'd123, 4'b1001, 2, "bp_add"}, 1'b1);
        waited = 0;
        while (!resp_valid && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!resp_valid) fail_now("bp resp_valid_timeout");
        repeat (5) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_cmd   = CMD_SUB;
            req_a     = 32'd1;
            req_b     = 32'd1;
            @(negedge clk);
            check("bp req_ready", 64'(req_ready), 64'(0));
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a multiply: no response may follow.
        v = '{CMD_MUL, 32'd12345, 32'd678, 32'd8369910, 4'b1001, 34, "mul_abort"};
        issue(v, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort resp_valid", 64'(resp_valid), 64'(0));
        check("abort req_ready", 64'(req_ready), 64'(0));
        check("abort dp_b", 64'(dp_b), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort idle resp_valid", 64'(resp_valid), 64'(0));
        check("abort idle req_ready", 64'(req_ready), 64'(1));

        issue('{CMD_CMP, 32'd1, 32'd2, 32'd0, 4'b0101, 2, "cmp_1_2"}, 1'b1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
